mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Used by mem_arbiter and arb_pick.
package mem_arb_pkg;

   localparam int unsigned NUM_PORTS = 2;
   localparam int unsigned PORT_INST = 0;
   localparam int unsigned PORT_DATA = 1;
   localparam int unsigned ARB_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   // Busy counter increment that sticks at all-ones.
   function automatic logic [ARB_CNT_W-1:0] cnt_sat_inc(input logic [ARB_CNT_W-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + ARB_CNT_W'(1);
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the instruction and data ports.
// ARB_RR_EN selects round-robin; otherwise the data port has fixed priority.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_cs_i,
   input  logic                 last_i,
   output logic                 any_c,
   output logic                 winner_c
);

`ifdef ARB_RR_EN
   always_comb begin
      any_c    = |req_cs_i;
      winner_c = req_cs_i[PORT_DATA];
      // Contention goes to whichever port was not served last.
      if (req_cs_i[PORT_INST] && req_cs_i[PORT_DATA]) begin
         winner_c = ~last_i;
      end
   end
`else
   logic unused_last;
   assign unused_last = last_i;

   always_comb begin
      any_c    = |req_cs_i;
      winner_c = req_cs_i[PORT_DATA];
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction and data CMU ports onto one single-ported memory.
// Build with ARB_RR_EN defined for round-robin, else data port has fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_cs,
   input  logic [1:0]            req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr0,
   input  logic [ADDR_WIDTH-1:0] req_addr1,
   input  logic [DATA_WIDTH-1:0] req_wdata0,
   input  logic [DATA_WIDTH-1:0] req_wdata1,
   output logic [1:0]            req_ack,
   output logic [1:0]            req_err,
   output logic [DATA_WIDTH-1:0] req_rdata,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
);

   localparam logic [ARB_CNT_W-1:0] TO_CNT = ARB_CNT_W'(TIMEOUT);
   localparam bit                   TO_EN  = (TIMEOUT != 0);

   arb_state_e            state_q,     state_d;
   logic                  owner_q,     owner_d;
   logic                  last_q,      last_d;
   logic [ARB_CNT_W-1:0]  cnt_q,       cnt_d;
   logic [ARB_CNT_W-1:0]  cnt_inc;
   logic                  mem_cs_q,    mem_cs_d;
   logic                  mem_we_q,    mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]            req_ack_q,   req_ack_d;
   logic [1:0]            req_err_q,   req_err_d;
   logic [DATA_WIDTH-1:0] req_rdata_q, req_rdata_d;
   logic                  pick_any_c;
   logic                  pick_winner_c;

   arb_pick u_pick (
      .req_cs_i (req_cs),
      .last_i   (last_q),
      .any_c    (pick_any_c),
      .winner_c (pick_winner_c)
   );

   // State and output registers; reset drops mem_cs immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         req_ack_q   <= '0;
         req_err_q   <= '0;
         req_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         req_ack_q   <= req_ack_d;
         req_err_q   <= req_err_d;
         req_rdata_q <= req_rdata_d;
      end
   end

   // Next-state logic; ack/err/rdata are single-cycle pulses.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      mem_cs_d    = mem_cs_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      req_ack_d   = '0;
      req_err_d   = '0;
      req_rdata_d = '0;
      cnt_inc     = cnt_sat_inc(cnt_q);

      unique case (state_q)
         IDLE: begin
            if (pick_any_c) begin
               state_d     = BUSY;
               owner_d     = pick_winner_c;
               last_d      = pick_winner_c;
               cnt_d       = '0;
               mem_cs_d    = 1'b1;
               mem_we_d    = req_we[pick_winner_c];
               mem_addr_d  = pick_winner_c ? req_addr1  : req_addr0;
               mem_wdata_d = pick_winner_c ? req_wdata1 : req_wdata0;
            end
         end
         BUSY: begin
            cnt_d = cnt_inc;
            // A memory ack beats a timeout landing on the same edge.
            if (mem_ack) begin
               req_ack_d[owner_q] = 1'b1;
               if (!mem_we_q) begin
                  req_rdata_d = mem_rdata;
               end
               mem_cs_d = 1'b0;
               mem_we_d = 1'b0;
               state_d  = RELEASE;
            end else if (TO_EN && (cnt_inc == TO_CNT)) begin
               req_ack_d[owner_q] = 1'b1;
               req_err_d[owner_q] = 1'b1;
               mem_cs_d = 1'b0;
               mem_we_d = 1'b0;
               state_d  = RELEASE;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign req_ack   = req_ack_q;
   assign req_err   = req_err_q;
   assign req_rdata = req_rdata_q;
   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
